lc3_writeback: RTL

- LC3 writeback stage. Selects the result (ALU, memory or PC path), writes it into the 8x16 general register file and updates the NZP condition code.
- Drives the writeback_out bus: enableWB_status, psr, VSR1, VSR2.
- Sits downstream of execute/memaccess. VSR1/VSR2 feed operand reads back to execute.

---
 rtl/lc3_writeback.sv | 100 ++++++++++
 1 files changed

// File: rtl/lc3_writeback.sv
// LC3 writeback stage: selects the ALU, memory or PC result, writes it into the
// general register file, updates the NZP condition code and serves two read ports.
module lc3_writeback #(
  parameter int                 DATA_W      = 16,
  parameter int                 NUM_REGS    = 8,
  parameter logic [DATA_W-1:0]  REG_RST_VAL = 16'h0000
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        enable_writeback,
  input  logic [1:0]                  W_Control,
  input  logic [DATA_W-1:0]           aluout,
  input  logic [DATA_W-1:0]           memout,
  input  logic [DATA_W-1:0]           pcout,
  input  logic [$clog2(NUM_REGS)-1:0] dr,
  input  logic [$clog2(NUM_REGS)-1:0] sr1,
  input  logic [$clog2(NUM_REGS)-1:0] sr2,
  output logic                        enableWB_status,
  output logic [2:0]                  psr,
  output logic [DATA_W-1:0]           VSR1,
  output logic [DATA_W-1:0]           VSR2
);

  localparam logic [1:0] SEL_ALU = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_PC  = 2'b10;
  localparam logic [1:0] SEL_RSV = 2'b11;

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic [2:0]        r_psr;
  logic              r_enable_wb_status;

  logic [DATA_W-1:0] w_wb_data;
  logic              w_wr_valid;

  // Condition code of a result: negative wins, then zero, otherwise positive.
  function automatic logic [2:0] f_nzp(input logic [DATA_W-1:0] data);
    logic [2:0] nzp;
    if (data[DATA_W-1]) begin
      nzp = 3'b100;
    end else if (data == {DATA_W{1'b0}}) begin
      nzp = 3'b010;
    end else begin
      nzp = 3'b001;
    end
    return nzp;
  endfunction

  // Result source mux and write qualification; the reserved encoding never writes.
  always_comb begin
    w_wb_data  = aluout;
    w_wr_valid = 1'b0;
    case (W_Control)
      SEL_ALU: begin
        w_wb_data  = aluout;
        w_wr_valid = enable_writeback;
      end
      SEL_MEM: begin
        w_wb_data  = memout;
        w_wr_valid = enable_writeback;
      end
      SEL_PC: begin
        w_wb_data  = pcout;
        w_wr_valid = enable_writeback;
      end
      SEL_RSV: begin
        w_wb_data  = aluout;
        w_wr_valid = 1'b0;
      end
      default: begin
        w_wb_data  = aluout;
        w_wr_valid = 1'b0;
      end
    endcase
  end

  // Register file, condition code and status update; reset drops any concurrent write.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= REG_RST_VAL;
      end
      r_psr              <= 3'b000;
      r_enable_wb_status <= 1'b0;
    end else begin
      r_enable_wb_status <= enable_writeback;
      if (w_wr_valid) begin
        r_regs[dr] <= w_wb_data;
        r_psr      <= f_nzp(w_wb_data);
      end
    end
  end

  // Reads come straight from the array: a same-cycle write is visible only after the edge.
  assign VSR1            = r_regs[sr1];
  assign VSR2            = r_regs[sr2];
  assign psr             = r_psr;
  assign enableWB_status = r_enable_wb_status;

endmodule
